// File: rtl/reg_desp_ctrl.sv
// Controller for an external parallel-load / serial shift register: TX loads a word and shifts it out,
// RX shifts a serial stream in; the completed register word is reported on result with a one-cycle pulse.
module reg_desp_ctrl #(
   parameter int         WIDTH      = 4,
   parameter logic [1:0] MODE_LOAD  = 2'b10,
   parameter logic [1:0] MODE_SHIFT = 2'b00
) (
   input  logic             clk,
   input  logic             reset_l,
   // Request handshake: a request is taken on a rising edge where req_valid && req_ready;
   // req_valid may be held across busy periods, the fields are only sampled at that edge.
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic             req_dir,
   input  logic [WIDTH-1:0] req_data,
   input  logic             abort,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             enb,
   output logic             dir,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] d,
   output logic             s_in,
   input  logic [WIDTH-1:0] q,
   input  logic             s_out,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          rx_q;

   assign req_ready = (state == IDLE) && !abort;
   assign s_in      = (state == SHIFT && rx_q) ? ser_in : 1'b0;
   assign ser_out   = ser_valid ? s_out : 1'b0;
   assign state_dbg = state;

   // Control outputs are registered together with the state, so they always match the state they describe.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state        <= IDLE;
         cnt          <= '0;
         rx_q         <= 1'b0;
         dir          <= 1'b0;
         enb          <= 1'b0;
         mode         <= MODE_SHIFT;
         d            <= '0;
         ser_valid    <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (abort && state != IDLE) begin
            state     <= IDLE;
            cnt       <= '0;
            enb       <= 1'b0;
            mode      <= MODE_SHIFT;
            d         <= '0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (req_valid && req_ready) begin
                     rx_q <= req_op;
                     dir  <= req_dir;
                     cnt  <= '0;
                     enb  <= 1'b1;
                     busy <= 1'b1;
                     if (req_op) begin
                        state <= SHIFT;
                        mode  <= MODE_SHIFT;
                     end else begin
                        state <= LOAD;
                        mode  <= MODE_LOAD;
                        d     <= req_data;
                     end
                  end
               end
               LOAD: begin
                  // Only TX passes through LOAD, so the following shifts drive ser_out.
                  state     <= SHIFT;
                  cnt       <= '0;
                  mode      <= MODE_SHIFT;
                  d         <= '0;
                  ser_valid <= 1'b1;
               end
               SHIFT: begin
                  if (cnt == CNT_LAST) begin
                     state     <= DONE;
                     cnt       <= '0;
                     enb       <= 1'b0;
                     ser_valid <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DONE: begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  result       <= q;
                  result_valid <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/reg_desp_ctrl.md
REG_DESP_CTRL -- requirements
Module: reg_desp_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, shift-register width and shift count per operation.
REQ-002 Parameter MODE_LOAD, default 2'b10, MODE code for parallel load.
REQ-003 Parameter MODE_SHIFT, default 2'b00, MODE code for serial shift.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESET_L  input  1  reset, asynchronous, active-low.
REQ-006 REQ_VALID  input  1  operation request.
REQ-007 REQ_READY  output  1  controller can accept a request.
REQ-008 REQ_OP  input  1  operation: 0 = TX (load, then shift out), 1 = RX (shift in).
REQ-009 REQ_DIR  input  1  shift direction: 1 = left (S_IN into Q[0], S_OUT = Q[3]); 0 = right.
REQ-010 REQ_DATA  input  WIDTH  parallel word for TX.
REQ-011 ABORT  input  1  synchronous cancel of the current operation.
REQ-012 SER_IN  input  1  serial data for RX.
REQ-013 SER_OUT  output  1  serial data for TX.
REQ-014 SER_VALID  output  1  SER_OUT is valid this cycle.
REQ-015 ENB, DIR, MODE[1:0], D[WIDTH-1:0], S_IN  outputs  control and data to the shift register.
REQ-016 Q[WIDTH-1:0], S_OUT  inputs  shift-register state and serial output.
REQ-017 RESULT  output  WIDTH  last completed register word.
REQ-018 RESULT_VALID  output  1  one-cycle completion pulse.
REQ-019 BUSY  output  1  high whenever state != IDLE.

Function
REQ-020 FSM states: IDLE, LOAD, SHIFT, DONE; 2-bit shift counter CNT.
REQ-021 REQ_READY = (state == IDLE) && !ABORT; handshake = REQ_VALID && REQ_READY at the rising edge.
REQ-022 On handshake, capture REQ_OP, REQ_DIR, REQ_DATA; TX goes to LOAD; RX goes to SHIFT with CNT = 0.
REQ-023 LOAD (one cycle): ENB = 1, MODE = MODE_LOAD, D = captured data; next state SHIFT, CNT = 0.
REQ-024 SHIFT: ENB = 1, MODE = MODE_SHIFT, DIR = captured dir; CNT increments each cycle; after the WIDTH-th cycle (CNT == WIDTH-1), next state DONE.
REQ-025 SHIFT with TX: S_IN = 0, SER_OUT = S_OUT (combinational), SER_VALID = 1.
REQ-026 SHIFT with RX: S_IN = SER_IN (combinational), SER_VALID = 0, SER_OUT = 0.
REQ-027 DONE (one cycle): ENB = 0; next state IDLE. On that edge, RESULT <= Q and RESULT_VALID = 1 for exactly the following cycle.
REQ-028 Outside LOAD and SHIFT: ENB = 0, MODE = MODE_SHIFT, D = 0, S_IN = 0, SER_VALID = 0.
REQ-029 Latency from handshake edge k: TX LOAD k+1, SHIFT k+2..k+5, DONE k+6, RESULT_VALID and REQ_READY k+7; RX SHIFT k+1..k+4, DONE k+5, RESULT_VALID k+6.
REQ-030 Back-to-back: a request is accepted in the same IDLE cycle in which RESULT_VALID is high.
REQ-031 ABORT high in LOAD, SHIFT or DONE: next state IDLE, CNT = 0, no RESULT_VALID, RESULT unchanged; ENB = 0 from the next cycle.
REQ-032 ABORT and REQ_VALID together in IDLE: ABORT wins; the request is not accepted.
REQ-033 REQ_VALID outside IDLE is ignored; captured fields do not change.

Reset
REQ-034 While RESET_L = 0: state IDLE, CNT = 0, captured fields 0, RESULT = 0, RESULT_VALID = 0, ENB = 0, MODE = MODE_SHIFT, D = 0, S_IN = 0, SER_VALID = 0, BUSY = 0.
REQ-035 Reset asserted mid-operation aborts immediately (asynchronously), with no RESULT_VALID.
REQ-036 The first request is accepted on the first rising edge after release.

Verification
REQ-037 TX, DIR = 1, DATA = 4'hA, controller connected to the shift register -> LOAD at k+1; SER_OUT = 1,0,1,0 on k+2..k+5; RESULT_VALID at k+7 with RESULT = 4'h0.
REQ-038 RX, DIR = 1, SER_IN = 1,1,0,1 on k+1..k+4 -> RESULT = 4'hD and RESULT_VALID high at k+6; SER_VALID stays 0.
REQ-039 ABORT during the second SHIFT cycle of a TX -> IDLE the next cycle; ENB = 0; no RESULT_VALID; RESULT keeps its prior value.
REQ-040 REQ_VALID held high across two TX operations -> second handshake in the RESULT_VALID cycle; BUSY low for exactly that one cycle.
REQ-041 RESET_L dropped during SHIFT -> all outputs at reset values in the same cycle; after release, RX completes normally.
REQ-042 ABORT = 1 and REQ_VALID = 1 in IDLE -> REQ_READY = 0; no state change.
